// File: rtl/mips_dmem_responder_if.sv
// mips_dmem_responder_if: request/response handshake bundle between core and data-memory responder
interface mips_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_width;
    logic        req_sext;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_width, req_sext, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_width, req_sext, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: wait-state data-memory responder with byte/half/word lanes, extension and error checks
module mips_dmem_responder #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input logic                  clk,
    input logic                  reset,
    mips_dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WC = 4'(WAIT_CYC);
    localparam bit         ZW = (WAIT_CYC == 0);

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we, l_sext;
    logic [31:0] l_addr, l_wdata;
    logic [1:0]  l_width;
    logic [31:0] mem [2**ADDR_W];

    logic        a_we, a_sext, a_err, do_acc;
    logic [31:0] a_addr, a_wdata, rd_word, ld_data, rsp_d, mask32, wrep, merged;
    logic [1:0]  a_width;
    logic [3:0]  mask4;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [ADDR_W-1:0] idx;

    // With zero wait states the access happens in the accept cycle, straight from the bus
    always_comb begin
        a_we     = ZW ? bus.req_we    : l_we;
        a_sext   = ZW ? bus.req_sext  : l_sext;
        a_addr   = ZW ? bus.req_addr  : l_addr;
        a_wdata  = ZW ? bus.req_wdata : l_wdata;
        a_width  = ZW ? bus.req_width : l_width;
        do_acc   = ZW ? (state == S_IDLE && bus.req_valid) : (state == S_WAIT && cnt == 4'd0);
        idx      = a_addr[ADDR_W+1:2];
        rd_word  = mem[idx];
        a_err    = (a_width == 2'b11) || (a_width == 2'b01 && a_addr[0]) ||
                   (a_width == 2'b10 && a_addr[1:0] != 2'b00) || (|a_addr[31:ADDR_W+2]);
        byte_sel = 8'(rd_word >> {a_addr[1:0], 3'b000});
        half_sel = a_addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data  = a_width == 2'b00 ? {{24{a_sext & byte_sel[7]}}, byte_sel} :
                   a_width == 2'b01 ? {{16{a_sext & half_sel[15]}}, half_sel} : rd_word;
        rsp_d    = (a_we || a_err) ? 32'd0 : ld_data;
        mask4    = a_width == 2'b00 ? 4'b0001 << a_addr[1:0] :
                   a_width == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        mask32   = {{8{mask4[3]}}, {8{mask4[2]}}, {8{mask4[1]}}, {8{mask4[0]}}};
        wrep     = a_width == 2'b00 ? {4{a_wdata[7:0]}} :
                   a_width == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
        merged   = (rd_word & ~mask32) | (wrep & mask32);
    end

    // Array is never reset; a reset mid-request forces IDLE so do_acc cannot fire
    always_ff @(posedge clk)
        if (do_acc && a_we && !a_err)
            mem[idx] <= merged;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            l_we          <= 1'b0;
            l_sext        <= 1'b0;
            l_addr        <= 32'd0;
            l_wdata       <= 32'd0;
            l_width       <= 2'b00;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    l_we          <= bus.req_we;
                    l_sext        <= bus.req_sext;
                    l_addr        <= bus.req_addr;
                    l_wdata       <= bus.req_wdata;
                    l_width       <= bus.req_width;
                    bus.req_ready <= 1'b0;
                    cnt           <= WC;
                    state         <= ZW ? S_RESP : S_WAIT;
                    if (ZW) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= rsp_d;
                        bus.rsp_err   <= a_err;
                    end
                end
                S_WAIT: if (cnt == 4'd0) begin
                    state         <= S_RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= rsp_d;
                    bus.rsp_err   <= a_err;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                S_RESP: if (bus.rsp_ready) begin
                    state         <= S_IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: directed vectors with hand-computed results for the data-memory responder
module tb_mips_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rd;
    logic        e;

    mips_dmem_responder_if bus();

    mips_dmem_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, latency check, optional response stall, handshake
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] width, input logic sext,
                        input int hold, output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        chk({tag, ".ready_idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_width = width;
        bus.req_sext  = sext;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            chk({tag, ".ready_busy"}, 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 32'(n - 1), 32'd3);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, bus.rsp_rdata, rdata);
            chk({tag, ".hold_err"}, 32'(bus.rsp_err), 32'(err));
            chk({tag, ".hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        chk({tag, ".ready_resp"}, 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_width = 2'b00;
        bus.req_sext  = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rdata", bus.rsp_rdata, 32'd0);
        chk("rst.err", 32'(bus.rsp_err), 32'd0);
        chk("rst.ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b1;

        xact("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd, e);
        chk("st_w10.rdata", rd, 32'd0);
        chk("st_w10.err", 32'(e), 32'd0);
        xact("ld_w10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b1, 0, rd, e);
        chk("ld_w10.rdata", rd, 32'hDEADBEEF);
        chk("ld_w10.err", 32'(e), 32'd0);

        xact("ld_b13s", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, rd, e);
        chk("ld_b13s.rdata", rd, 32'hFFFFFFDE);
        xact("ld_b13z", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, rd, e);
        chk("ld_b13z.rdata", rd, 32'h000000DE);
        xact("ld_h12s", 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 0, rd, e);
        chk("ld_h12s.rdata", rd, 32'hFFFFDEAD);
        xact("ld_b10s", 1'b0, 32'h10, 32'h0, 2'b00, 1'b1, 0, rd, e);
        chk("ld_b10s.rdata", rd, 32'hFFFFFFEF);

        xact("st_b11", 1'b1, 32'h11, 32'hAAAAAA55, 2'b00, 1'b0, 0, rd, e);
        chk("st_b11.err", 32'(e), 32'd0);
        xact("ld_w10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, e);
        chk("ld_w10b.rdata", rd, 32'hDEAD55EF);
        xact("ld_h10z", 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 0, rd, e);
        chk("ld_h10z.rdata", rd, 32'h000055EF);

        xact("st_h22", 1'b1, 32'h22, 32'hFFFF8001, 2'b01, 1'b0, 0, rd, e);
        xact("st_h20", 1'b1, 32'h20, 32'h00001234, 2'b01, 1'b0, 0, rd, e);
        xact("ld_w20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, rd, e);
        chk("ld_w20.rdata", rd, 32'h80011234);

        xact("ld_w12", 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 0, rd, e);
        chk("ld_w12.err", 32'(e), 32'd1);
        chk("ld_w12.rdata", rd, 32'd0);
        xact("ld_x10", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, rd, e);
        chk("ld_x10.err", 32'(e), 32'd1);
        chk("ld_x10.rdata", rd, 32'd0);
        xact("ld_h11", 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 0, rd, e);
        chk("ld_h11.err", 32'(e), 32'd1);
        xact("ld_wffc", 1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, 0, rd, e);
        chk("ld_wffc.err", 32'(e), 32'd0);
        xact("st_w0", 1'b1, 32'h0, 32'hCAFEF00D, 2'b10, 1'b0, 0, rd, e);
        xact("st_w1000", 1'b1, 32'h1000, 32'h11111111, 2'b10, 1'b0, 0, rd, e);
        chk("st_w1000.err", 32'(e), 32'd1);
        chk("st_w1000.rdata", rd, 32'd0);
        xact("ld_w0", 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 0, rd, e);
        chk("ld_w0.rdata", rd, 32'hCAFEF00D);

        xact("stall", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 5, rd, e);
        chk("stall.rdata", rd, 32'h000000DE);

        // Reset while the store is still counting wait states
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h12345678;
        bus.req_width = 2'b10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rstw.ready_busy", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rstw.async_ready", 32'(bus.req_ready), 32'd1);
        chk("rstw.async_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstw.valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstw.ready", 32'(bus.req_ready), 32'd1);
        xact("rstw.ld", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, e);
        chk("rstw.ld_rdata", rd, 32'hDEAD55EF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
